// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sequencing one shared full_adder cell, LSB first
module full_adder (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic c
);
  assign sum = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0] count;
  logic carry, fa_sum, fa_carry;
  full_adder u_fa (.sum(fa_sum), .carry(fa_carry), .a(a_sr[0]), .b(b_sr[0]), .c(carry));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr <= '0;
      b_sr <= '0;
      count <= '0;
      carry <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr <= A;
          b_sr <= B;
          carry <= cin;
          count <= '0;
          busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          sum <= {fa_sum, sum[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          carry <= fa_carry;
          count <= count + 1'b1;
          // carry still holds the carry into the MSB on the final bit
          if (count == CW'(WIDTH - 1)) begin
            cout <= fa_carry;
            ovf <= carry ^ fa_carry;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: table-driven directed checks of the bit-serial adder plus handshake corner cases
module tb_serial_adder_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic busy, done, cout, ovf;
  logic [7:0] sum;
  int errors = 0, checks = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one start at edge E0, then counts edges until done (bounded).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output int edges, output int busy_cycles);
    A = a; B = b; cin = ci; start = 1'b1;
    step();
    start = 1'b0;
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cycles++;
      step();
      edges++;
    end
  endtask

  vec_t vecs[8];
  int edges, bc;

  initial begin
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    step(); step();
    rst = 1'b0;
    chk("reset_sum", sum, 8'h00);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, edges, bc);
      chk($sformatf("v%0d_latency", i), edges, 8);
      chk($sformatf("v%0d_busy_cycles", i), bc, 8);
      chk($sformatf("v%0d_done_busy", i), busy, 0);
      chk($sformatf("v%0d_sum", i), sum, vecs[i].s);
      chk($sformatf("v%0d_cout", i), cout, vecs[i].co);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ov);
      step();
      chk($sformatf("v%0d_done_pulse", i), done, 0);
      step();
      chk($sformatf("v%0d_hold_sum", i), sum, vecs[i].s);
    end

    // start while busy and during DONE must be ignored
    A = 8'h12; B = 8'h34; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    A = 8'hFF; B = 8'hFF; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    edges = 3;
    while (!done && edges < 20) begin
      step();
      edges++;
    end
    chk("busy_start_latency", edges, 8);
    chk("busy_start_sum", sum, 8'h46);
    chk("busy_start_cout", cout, 0);
    chk("busy_start_ovf", ovf, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("done_start_idle_busy", busy, 0);
    chk("done_start_idle_done", done, 0);
    bc = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done || busy) bc++;
    end
    chk("done_start_ignored", bc, 0);
    chk("done_start_sum_hold", sum, 8'h46);

    // reset in the middle of an operation, after a result with cout/ovf set
    run_op(8'h80, 8'h80, 1'b0, edges, bc);
    step();
    chk("pre_rst_cout", cout, 1);
    A = 8'h3C; B = 8'h0F; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 8'h00);
    chk("midrst_cout", cout, 0);
    chk("midrst_ovf", ovf, 0);
    bc = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done || busy) bc++;
    end
    chk("midrst_no_done", bc, 0);
    run_op(8'h3C, 8'h0F, 1'b1, edges, bc);
    chk("post_rst_latency", edges, 8);
    chk("post_rst_sum", sum, 8'h4C);
    chk("post_rst_cout", cout, 0);
    chk("post_rst_ovf", ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
